// File: rtl/note_event_master.sv
// Note-event to synth-voice bus master: allocates one of eight voices per MIDI event
// and issues the KEY/FREQ register writes for that voice over Avalon-MM.
module note_event_voice (
    input  logic       active,
    input  logic [6:0] note,
    input  logic [6:0] evt_note,
    output logic       hit,
    output logic       free
);
    assign hit  = active && (note == evt_note);
    assign free = !active;
endmodule

module note_event_master #(
    parameter logic [5:0] BASE_KEY  = 6'd32,
    parameter logic [5:0] BASE_FREQ = 6'd40
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        EVT_VALID,
    output logic        EVT_READY,
    input  logic        EVT_ON,
    input  logic [6:0]  EVT_NOTE,
    output logic [5:0]  AVM_ADDR,
    output logic [3:0]  AVM_BYTE_EN,
    output logic        AVM_WRITE,
    output logic        AVM_CS,
    output logic [31:0] AVM_WRITEDATA,
    input  logic        AVM_WAITREQUEST,
    output logic [7:0]  VOICE_ACTIVE,
    output logic        DROPPED
);
    typedef enum logic [1:0] {IDLE, WR_KEYOFF, WR_FREQ, WR_KEYON} state_t;

    state_t          state, go, dec_state, seq_next;
    logic [7:0]      act, hit, free;
    logic [7:0][6:0] notes;
    logic [2:0]      steal_ptr, hit_idx, free_idx, dec_v, cur_v, op_v;
    logic [6:0]      cur_note, op_note;
    logic            any_hit, any_free, off_only, accept, adv;

    function automatic logic [5:0] addr_of(input state_t s, input logic [2:0] v);
        case (s)
            WR_FREQ:            addr_of = BASE_FREQ + {3'b0, v};
            WR_KEYOFF, WR_KEYON: addr_of = BASE_KEY + {3'b0, v};
            default:            addr_of = 6'd0;
        endcase
    endfunction

    function automatic logic [31:0] data_of(input state_t s, input logic [6:0] n);
        case (s)
            WR_FREQ:  data_of = {25'b0, n};
            WR_KEYON: data_of = 32'd1;
            default:  data_of = 32'd0;
        endcase
    endfunction

    for (genvar g = 0; g < 8; g++) begin : g_voice
        note_event_voice u_voice (
            .active  (act[g]),
            .note    (notes[g]),
            .evt_note(EVT_NOTE),
            .hit     (hit[g]),
            .free    (free[g])
        );
    end

    // Descending scan so the lowest matching / free index wins.
    always_comb begin
        hit_idx  = '0;
        free_idx = '0;
        any_hit  = 1'b0;
        any_free = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            if (hit[i]) begin
                hit_idx = 3'(i);
                any_hit = 1'b1;
            end
            if (free[i]) begin
                free_idx = 3'(i);
                any_free = 1'b1;
            end
        end
    end

    always_comb begin
        dec_v     = steal_ptr;
        dec_state = IDLE;
        if (EVT_ON) begin
            if (any_hit) begin
                dec_v     = hit_idx;
                dec_state = WR_KEYOFF;
            end else if (any_free) begin
                dec_v     = free_idx;
                dec_state = WR_FREQ;
            end else begin
                dec_state = WR_KEYOFF;
            end
        end else if (any_hit) begin
            dec_v     = hit_idx;
            dec_state = WR_KEYOFF;
        end

        case (state)
            WR_KEYOFF: seq_next = off_only ? IDLE : WR_FREQ;
            WR_FREQ:   seq_next = WR_KEYON;
            default:   seq_next = IDLE;
        endcase

        accept  = EVT_VALID && (state == IDLE);
        adv     = accept || ((state != IDLE) && !AVM_WAITREQUEST);
        go      = (state == IDLE) ? dec_state : seq_next;
        op_v    = (state == IDLE) ? dec_v : cur_v;
        op_note = (state == IDLE) ? EVT_NOTE : cur_note;
    end

    assign EVT_READY    = (state == IDLE);
    assign VOICE_ACTIVE = act;

    // Bus outputs are loaded on the same edge the state moves, so they hold during stalls.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state         <= IDLE;
            act           <= '0;
            notes         <= '0;
            steal_ptr     <= '0;
            cur_v         <= '0;
            cur_note      <= '0;
            off_only      <= 1'b0;
            DROPPED       <= 1'b0;
            AVM_ADDR      <= '0;
            AVM_WRITEDATA <= '0;
            AVM_WRITE     <= 1'b0;
            AVM_CS        <= 1'b0;
            AVM_BYTE_EN   <= '0;
        end else begin
            DROPPED <= accept && !EVT_ON && !any_hit;
            if (adv) begin
                state         <= go;
                AVM_ADDR      <= addr_of(go, op_v);
                AVM_WRITEDATA <= data_of(go, op_note);
                AVM_WRITE     <= (go != IDLE);
                AVM_CS        <= (go != IDLE);
                AVM_BYTE_EN   <= (go != IDLE) ? 4'hF : 4'h0;
            end
            if (accept) begin
                cur_v    <= dec_v;
                cur_note <= EVT_NOTE;
                off_only <= !EVT_ON;
                if (EVT_ON) begin
                    act[dec_v]   <= 1'b1;
                    notes[dec_v] <= EVT_NOTE;
                    if (!any_hit && !any_free)
                        steal_ptr <= steal_ptr + 3'd1;
                end else if (any_hit) begin
                    act[hit_idx] <= 1'b0;
                end
            end
        end
    end
endmodule

// File: doc/note_event_master.md
NOTE_EVENT_MASTER -- requirements
Module: note_event_master

Interface
REQ-001 SHALL have parameter BASE_KEY, default 6'd32, word address of the KEY register for voice 0 (voice v at BASE_KEY+v).
REQ-002 SHALL have parameter BASE_FREQ, default 6'd40, word address of the FREQ register for voice 0 (voice v at BASE_FREQ+v).
REQ-003 SHALL have port CLK, input, 1, single clock for all logic.
REQ-004 SHALL have port RESET, input, 1, reset, synchronous and active-high.
REQ-005 SHALL have port EVT_VALID, input, 1, note event present.
REQ-006 SHALL have port EVT_READY, output, 1, block can accept an event.
REQ-007 SHALL have port EVT_ON, input, 1, 1 = note-on, 0 = note-off.
REQ-008 SHALL have port EVT_NOTE, input, 7, MIDI note number.
REQ-009 SHALL have port AVM_ADDR, output, 6, Avalon-MM word address.
REQ-010 SHALL have port AVM_BYTE_EN, output, 4, byte enables.
REQ-011 SHALL have ports AVM_WRITE and AVM_CS, output, 1 each, write strobe and chip select.
REQ-012 SHALL have port AVM_WRITEDATA, output, 32, write data.
REQ-013 SHALL have port AVM_WAITREQUEST, input, 1, slave stall.
REQ-014 SHALL have port VOICE_ACTIVE, output, 8, per-voice active flags.
REQ-015 SHALL have port DROPPED, output, 1, one-cycle pulse for a discarded note-off.

Function
REQ-016 SHALL hold an 8-entry voice table, each entry {active, note[6:0]}, plus a 3-bit steal pointer STEAL_PTR.
REQ-017 SHALL implement FSM states IDLE, WR_KEYOFF, WR_FREQ, WR_KEYON.
REQ-018 SHALL assert EVT_READY only in IDLE; an event is accepted on a cycle where EVT_VALID and EVT_READY are both 1.
REQ-019 SHALL make the voice decision and update the voice table on the accept edge; the FSM leaves IDLE on that same edge.
REQ-020 Note-on, note matches an active voice v: sequence is WR_KEYOFF, WR_FREQ, WR_KEYON on v (retrigger).
REQ-021 Note-on, no match, free voice exists: select the lowest-index free voice v; sequence is WR_FREQ, WR_KEYON.
REQ-022 Note-on, no match, all 8 voices active: steal v = STEAL_PTR; sequence is WR_KEYOFF, WR_FREQ, WR_KEYON; STEAL_PTR increments mod 8 (7 wraps to 0); STEAL_PTR changes only on a steal.
REQ-023 Note-off matching active voice v (lowest index if several): clear v.active; sequence is WR_KEYOFF only.
REQ-024 Note-off with no match: no bus writes, DROPPED=1 on the cycle after accept, FSM remains in IDLE.
REQ-025 WR_KEYOFF SHALL drive AVM_ADDR=BASE_KEY+v and AVM_WRITEDATA=32'd0.
REQ-026 WR_FREQ SHALL drive AVM_ADDR=BASE_FREQ+v and AVM_WRITEDATA={25'b0,note}.
REQ-027 WR_KEYON SHALL drive AVM_ADDR=BASE_KEY+v and AVM_WRITEDATA=32'd1.
REQ-028 In every write state, AVM_WRITE=1, AVM_CS=1, AVM_BYTE_EN=4'hF; a write completes on a cycle with AVM_WAITREQUEST=0.
REQ-029 While AVM_WAITREQUEST=1, AVM_ADDR, AVM_WRITEDATA and the FSM state SHALL be held unchanged.
REQ-030 On completion the FSM advances to the next state in the sequence, or to IDLE after the last write; back-to-back writes have no idle gap.
REQ-031 In IDLE, AVM_WRITE=0, AVM_CS=0, AVM_ADDR=0, AVM_WRITEDATA=0, AVM_BYTE_EN=0.
REQ-032 VOICE_ACTIVE SHALL equal the table active bits, updated on the accept edge.
REQ-033 Latency with AVM_WAITREQUEST=0: accept at edge N; first write presented cycle N+1; a 2-write sequence returns EVT_READY=1 at cycle N+3, a 3-write sequence at cycle N+4.

Reset
REQ-034 When RESET=1 at a clock edge, the block SHALL enter IDLE, clear all table entries, set STEAL_PTR=0, VOICE_ACTIVE=0, DROPPED=0, and drive all AVM outputs to 0.
REQ-035 RESET during a stalled write SHALL abandon the transfer with AVM_WRITE=0 on the next cycle; no recovery writes are issued.

Verification
REQ-036 Reset, note-on 60, WAITREQUEST=0 -> writes (41? no) (40,60) then (32,1); VOICE_ACTIVE=8'h01; EVT_READY=1 three cycles after accept.
REQ-037 Note-ons 60..67, then note-on 70 -> writes (32,0), (40,70), (32,1); STEAL_PTR=1; note-on 71 -> writes target voice 1 (addresses 33/41).
REQ-038 Note-on 60, then note-off 60 -> single write (32,0); VOICE_ACTIVE=0. Note-off 61 -> no writes; DROPPED pulses once.
REQ-039 Hold WAITREQUEST=1 for 5 cycles during WR_FREQ -> AVM_ADDR/AVM_WRITEDATA stable all 5 cycles; EVT_READY=0 throughout; sequence then completes.
REQ-040 Assert RESET mid-stall in WR_KEYON -> AVM_WRITE=0 next cycle; VOICE_ACTIVE=0; EVT_READY=1 once RESET deasserts.
